rc4_result_collector: RTL
=========================

RC4_RESULT_COLLECTOR -- requirements
Module: rc4_result_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_CORES, default 4, SHALL be the number of cracking cores attached (range 1..8).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port start, input, 1 bit: a one-cycle pulse that begins a search.
REQ-006 Port clear, input, 1 bit: a one-cycle pulse that abandons or acknowledges a result and returns the block to IDLE.
REQ-007 Port core_success, input, NUM_CORES bits: per-core key-found level.
REQ-008 Port core_total_failure, input, NUM_CORES bits: per-core keyspace-exhausted level or pulse.
REQ-009 Port core_key, input, 24*NUM_CORES bits: per-core current secret_key; core i occupies bits [24i+23:24i].
REQ-010 Port stop, output, 1 bit: freeze, broadcast to every core.
REQ-011 Port found, output, 1 bit: a key was found.
REQ-012 Port exhausted, output, 1 bit: all cores failed.
REQ-013 Port winner_idx, output, 3 bits: index of the winning core.
REQ-014 Port found_key, output, 24 bits: the latched winning key.
REQ-015 Port hex0..hex5, output, 7 bits each: active-low seven-segment digits of found_key; hex0 shows the least significant nibble.
REQ-016 Port search_cycles, output, 32 bits: elapsed search time (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, SEARCH, FOUND and EXHAUSTED; the state is registered.
REQ-018 Transitions:
- IDLE->SEARCH on start.
- SEARCH->FOUND when any registered success bit is set.
- SEARCH->EXHAUSTED when done_mask is all ones and no success bit is set.
- FOUND, EXHAUSTED or SEARCH ->IDLE on clear.
- clear SHALL have priority over start.
REQ-019 core_success and core_total_failure SHALL each pass through one register stage before the FSM uses them.
REQ-020 Sampled success at edge N SHALL give state FOUND, found=1 and stop=1 after edge N+1; total latency from the input is 2 cycles.
REQ-021 stop SHALL be 0 only in SEARCH and 1 in all other states.
REQ-022 When several success bits are set in the same cycle, the lowest index SHALL win.
REQ-023 On entry to FOUND, winner_idx and found_key SHALL latch the winner's index and its core_key slice, and hold until clear or reset.
REQ-024 done_mask (NUM_CORES bits) SHALL set bit i sticky when registered total_failure[i] is 1; it clears on start, clear or reset.
REQ-025 Success SHALL take priority over exhaustion when both are possible in the same cycle.
REQ-026 Inputs SHALL be ignored in IDLE, FOUND and EXHAUSTED; a later success SHALL never overwrite a latched key.
REQ-027 found SHALL be 1 only in FOUND, and exhausted SHALL be 1 only in EXHAUSTED.
REQ-028 hex digits SHALL decode found_key nibbles 0-F while found=1, show all dashes (7'b0111111) while exhausted=1, and be blank (7'h7F) otherwise.
REQ-029 start received while in SEARCH SHALL be ignored.

Reset
REQ-030 On reset_n=0 the block SHALL immediately, regardless of clk, set state to IDLE and:
- stop=1, found=0, exhausted=0;
- winner_idx=0, found_key=0, done_mask=0;
- input registers to 0, search_cycles=0;
- hex outputs blank.
REQ-031 Reset asserted mid-SEARCH SHALL discard all progress; no key survives.

Configuration
REQ-032 Macro RC4_COLLECTOR_CYCLE_COUNT_EN SHALL control the elapsed-time counter.
- Defined: search_cycles is cleared on start and increments by 1 in every SEARCH cycle. It freezes in FOUND or EXHAUSTED and saturates at 32'hFFFFFFFF.
- Undefined: search_cycles is tied to 0 and no counter logic is built.

Verification
REQ-033 Reset, start, then core_success=4'b0100 with key2=24'h00_3A_5C -> 2 cycles later found=1, stop=1, winner_idx=2, found_key=24'h003A5C, hex digits read 003A5C.
REQ-034 core_success=4'b1010 in the same cycle -> winner_idx=1 and found_key equals key1.
REQ-035 total_failure pulses on cores 0, 1, 2 and 3 in different cycles -> EXHAUSTED one cycle after the last registered pulse, exhausted=1, found=0, dashes displayed.
REQ-036 Last failure pulse and core_success[3] sampled in the same cycle -> FOUND with winner_idx=3.
REQ-037 reset_n dropped mid-SEARCH between clock edges -> outputs take their reset values at once; clear and start pulsed together in IDLE -> the block stays in IDLE.
REQ-038 With the macro defined, start followed by success 100 cycles later -> search_cycles holds 101, steady through FOUND; with the macro undefined -> search_cycles=0.

Source files
------------

// File: rtl/rc4_result_collector.sv
// ---------------------------------------------------------------------------
// rc4_result_collector
//
// Collects the outcome of NUM_CORES parallel RC4 key-search cores. The first
// core to report success wins: its index and current key are latched, every
// core is frozen through stop, and the key is shown on six active-low
// seven-segment digits. If every core reports keyspace exhaustion without a
// success, the block reports exhausted and shows dashes.
//
// Optional feature macro: RC4_COLLECTOR_CYCLE_COUNT_EN
//   defined   -> search_cycles counts SEARCH cycles (cleared on start,
//                frozen in FOUND/EXHAUSTED, saturating)
//   undefined -> search_cycles is tied to zero
//
// Ports
//   clk                 clock, rising edge
//   reset_n             asynchronous active-low reset
//   start               one-cycle pulse, begins a search from IDLE
//   clear               one-cycle pulse, returns to IDLE (beats start)
//   core_success        per-core key-found level
//   core_total_failure  per-core keyspace-exhausted level/pulse
//   core_key            per-core current key, core i at [24i+23:24i]
//   stop                freeze to all cores, low only while searching
//   found / exhausted   result flags
//   winner_idx          index of winning core
//   found_key           latched winning key
//   hex0..hex5          active-low 7-seg digits of found_key (hex0 = LS nibble)
//   search_cycles       elapsed search time
// ---------------------------------------------------------------------------
module rc4_result_collector #(
    parameter int NUM_CORES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    clear,
    input  logic [NUM_CORES-1:0]    core_success,
    input  logic [NUM_CORES-1:0]    core_total_failure,
    input  logic [24*NUM_CORES-1:0] core_key,
    output logic                    stop,
    output logic                    found,
    output logic                    exhausted,
    output logic [2:0]              winner_idx,
    output logic [23:0]             found_key,
    output logic [6:0]              hex0,
    output logic [6:0]              hex1,
    output logic [6:0]              hex2,
    output logic [6:0]              hex3,
    output logic [6:0]              hex4,
    output logic [6:0]              hex5,
    output logic [31:0]             search_cycles
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEARCH    = 2'd1,
        FOUND     = 2'd2,
        EXHAUSTED = 2'd3
    } state_t;

    state_t                 state;
    logic [NUM_CORES-1:0]   success_p0;
    logic [NUM_CORES-1:0]   fail_p0;
    logic [NUM_CORES-1:0]   done_mask;
    logic                   any_success;
    logic                   all_done;
    logic [2:0]             win_idx_c;
    logic [23:0]            win_key_c;

    // Lowest set bit wins when several cores succeed together.
    function automatic logic [2:0] lowest_set(input logic [NUM_CORES-1:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] digit(input logic [3:0] nib, input logic f,
                                         input logic e);
        logic [6:0] s;
        if (f)      s = seg_decode(nib);
        else if (e) s = 7'h3F;
        else        s = 7'h7F;
        return s;
    endfunction

    // Stage p0: core status registered once before the FSM looks at it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            success_p0 <= '0;
            fail_p0    <= '0;
        end else begin
            success_p0 <= core_success;
            fail_p0    <= core_total_failure;
        end
    end

    assign any_success = |success_p0;
    // Folding the current registered failures into the check lets the final
    // pulse end the search one cycle after it is registered.
    assign all_done    = &(done_mask | fail_p0);
    assign win_idx_c   = lowest_set(success_p0);

    // The key is taken from the live core bus on the edge that enters FOUND.
    always_comb begin
        win_key_c = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_idx_c == 3'(i)) win_key_c = core_key[24*i +: 24];
        end
    end

    // Stage p1: result FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            stop       <= 1'b1;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            winner_idx <= '0;
            found_key  <= '0;
            done_mask  <= '0;
        end else if (clear) begin
            state      <= IDLE;
            stop       <= 1'b1;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            winner_idx <= '0;
            found_key  <= '0;
            done_mask  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SEARCH;
                        stop      <= 1'b0;
                        done_mask <= '0;
                    end
                end
                SEARCH: begin
                    done_mask <= done_mask | fail_p0;
                    if (any_success) begin
                        state      <= FOUND;
                        stop       <= 1'b1;
                        found      <= 1'b1;
                        winner_idx <= win_idx_c;
                        found_key  <= win_key_c;
                    end else if (all_done) begin
                        state     <= EXHAUSTED;
                        stop      <= 1'b1;
                        exhausted <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RC4_COLLECTOR_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (state == IDLE && start && !clear) begin
            cycle_cnt <= '0;
        end else if (state == SEARCH && cycle_cnt != 32'hFFFF_FFFF) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    assign search_cycles = cycle_cnt;
`else
    assign search_cycles = '0;
`endif

    assign hex0 = digit(found_key[3:0],   found, exhausted);
    assign hex1 = digit(found_key[7:4],   found, exhausted);
    assign hex2 = digit(found_key[11:8],  found, exhausted);
    assign hex3 = digit(found_key[15:12], found, exhausted);
    assign hex4 = digit(found_key[19:16], found, exhausted);
    assign hex5 = digit(found_key[23:20], found, exhausted);

endmodule
